// File: rtl/risc_v_mike_imem_ctrl_if.sv
// Instruction-memory controller bus: boot-load stream, fetch/debug read ports, memory array port.
// slave = controller side, master = clients plus memory side.
interface risc_v_mike_imem_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              reload_req;
    logic              core_run;
    logic              load_err;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [31:0]       fetch_rdata;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_wr_addr;
    logic [31:0]       imem_wr_data;
    logic [ADDR_W-1:0] imem_rd_addr;
    logic [31:0]       imem_rd_data;

    modport slave (
        input  ld_valid, ld_data, ld_last, reload_req,
        input  fetch_req, fetch_addr, dbg_req, dbg_addr, imem_rd_data,
        output ld_ready, core_run, load_err,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output imem_wr_en, imem_wr_addr, imem_wr_data, imem_rd_addr
    );

    modport master (
        output ld_valid, ld_data, ld_last, reload_req,
        output fetch_req, fetch_addr, dbg_req, dbg_addr, imem_rd_data,
        input  ld_ready, core_run, load_err,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  imem_wr_en, imem_wr_addr, imem_wr_data, imem_rd_addr
    );
endinterface

// File: rtl/risc_v_mike_imem_ctrl.sv
// Boot-loads the instruction memory, then arbitrates its single read port between fetch and debug.
// Latency: writes land on the accepting edge; read data returns 1 cycle after grant.
// Backpressure: ld_ready high only while loading; losing reader waits, debug forced through after STARVE_LIMIT losses.
module risc_v_mike_imem_ctrl #(
    parameter int IMEM_DEPTH   = 16,
    parameter int ADDR_W       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    risc_v_mike_imem_ctrl_if.slave          bus
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_load_cnt;
    logic [3:0]        r_starve_cnt;
    logic              r_load_err;
    logic              r_fetch_rvalid;
    logic              r_dbg_rvalid;
    logic [31:0]       r_fetch_rdata;
    logic [31:0]       r_dbg_rdata;

    logic              w_load;
    logic              w_ld_acc;
    logic              w_at_end;
    logic              w_reload;
    logic              w_fetch_elig;
    logic              w_force_dbg;
    logic              w_fetch_gnt;
    logic              w_dbg_gnt;

    // Reset is treated as LOAD so the handshake outputs look like the reset state at once.
    assign w_load   = rst || (r_state == ST_LOAD);
    assign w_at_end = (r_load_cnt == ADDR_W'(IMEM_DEPTH - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_ld_acc     = 1'b0;
        w_reload     = 1'b0;
        w_fetch_elig = 1'b0;
        w_force_dbg  = 1'b0;
        w_fetch_gnt  = 1'b0;
        w_dbg_gnt    = 1'b0;

        if (w_load) begin
            w_ld_acc = bus.ld_valid;
            if (w_ld_acc && (bus.ld_last || w_at_end)) begin
                w_state_nxt = ST_RUN;
            end
        end else begin
            w_fetch_elig = bus.fetch_req;
            w_reload     = bus.reload_req;
            if (w_reload) begin
                w_state_nxt = ST_LOAD;
            end
        end

        w_force_dbg = bus.dbg_req && (r_starve_cnt == 4'(STARVE_LIMIT));
        w_dbg_gnt   = bus.dbg_req && (!w_fetch_elig || w_force_dbg);
        w_fetch_gnt = w_fetch_elig && !w_dbg_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_LOAD;
            r_load_cnt     <= '0;
            r_starve_cnt   <= '0;
            r_load_err     <= 1'b0;
            r_fetch_rvalid <= 1'b0;
            r_dbg_rvalid   <= 1'b0;
            r_fetch_rdata  <= '0;
            r_dbg_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_reload) begin
                r_load_cnt <= '0;
                r_load_err <= 1'b0;
            end else if (w_ld_acc) begin
                r_load_cnt <= r_load_cnt + ADDR_W'(1);
                if (w_at_end && !bus.ld_last) begin
                    r_load_err <= 1'b1;
                end
            end

            if (!bus.dbg_req || w_dbg_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            r_fetch_rvalid <= w_fetch_gnt;
            r_dbg_rvalid   <= w_dbg_gnt;
            if (w_fetch_gnt) begin
                r_fetch_rdata <= bus.imem_rd_data;
            end
            if (w_dbg_gnt) begin
                r_dbg_rdata <= bus.imem_rd_data;
            end
        end
    end

    assign bus.ld_ready     = w_load;
    assign bus.core_run     = !w_load;
    assign bus.load_err     = r_load_err;
    assign bus.imem_wr_en   = w_ld_acc;
    assign bus.imem_wr_addr = r_load_cnt;
    assign bus.imem_wr_data = bus.ld_data;
    assign bus.imem_rd_addr = w_dbg_gnt ? bus.dbg_addr : bus.fetch_addr;
    assign bus.fetch_gnt    = w_fetch_gnt;
    assign bus.dbg_gnt      = w_dbg_gnt;
    assign bus.fetch_rvalid = r_fetch_rvalid;
    assign bus.fetch_rdata  = r_fetch_rdata;
    assign bus.dbg_rvalid   = r_dbg_rvalid;
    assign bus.dbg_rdata    = r_dbg_rdata;

endmodule

// File: doc/risc_v_mike_imem_ctrl.md
# risc_v_mike_imem_ctrl

Controller that owns the instruction memory's write path and read port. After reset it runs a boot-load sequence, streaming program words into the memory over a valid/ready channel. It then releases the core and arbitrates the single combinational read port between the core's fetch unit and a debug reader. It sits between the memory array and its clients: fetch unit, boot loader, debug module.

## Interface
- IMEM_DEPTH, 16, number of 32-bit instruction words
- ADDR_W, 4, word-address width; IMEM_DEPTH = 2**ADDR_W
- STARVE_LIMIT, 4, consecutive lost debug cycles before debug is forced to win (range 1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when ld_valid & ld_ready
- ld_data  in  32  instruction word
- ld_last  in  1  final beat of program
- reload_req  in  1  single-cycle pulse; restart boot load
- core_run  out  1  core may fetch; high only in RUN
- load_err  out  1  sticky: memory filled without ld_last
- fetch_req  in  1  fetch read request
- fetch_addr  in  ADDR_W  fetch word address
- fetch_gnt  out  1  fetch granted this cycle
- fetch_rvalid  out  1  fetch data valid (1 cycle after grant)
- fetch_rdata  out  32  fetch data
- dbg_req  in  1  debug read request, held until granted
- dbg_addr  in  ADDR_W  debug word address
- dbg_gnt  out  1  debug granted this cycle
- dbg_rvalid  out  1  debug data valid (1 cycle after grant)
- dbg_rdata  out  32  debug data
- imem_wr_en  out  1  memory write strobe
- imem_wr_addr  out  ADDR_W  write address
- imem_wr_data  out  32  write data
- imem_rd_addr  out  ADDR_W  read address to memory
- imem_rd_data  in  32  combinational read data from memory

## Operation
- FSM states: LOAD (reset state), RUN.
- LOAD:
  - ld_ready=1.
  - Each accepted beat drives imem_wr_en=1, imem_wr_addr=load_cnt, imem_wr_data=ld_data, combinationally in the same cycle; load_cnt then increments.
  - Transition to RUN on an accepted beat with ld_last=1.
  - Also transition to RUN on an accepted beat at load_cnt=IMEM_DEPTH-1. If ld_last=0 on that beat, set load_err. No wrap, no overwrite.
  - fetch_gnt forced 0. Debug reads remain allowed.
- RUN:
  - ld_ready=0, imem_wr_en=0, core_run=1.
  - reload_req=1 → LOAD next cycle: load_cnt←0, load_err←0.
  - reload_req is ignored while in LOAD.
- Read arbitration (combinational, every cycle):
  - Fetch eligible only in RUN. Fixed priority fetch > debug.
  - Exception: starve_cnt=STARVE_LIMIT forces debug to win that cycle.
  - imem_rd_addr = winner's address, else fetch_addr.
  - starve_cnt: increments (saturating) each cycle dbg_req=1 and dbg_gnt=0; clears on dbg_gnt or dbg_req=0.
- Responses:
  - Winner's rvalid←1 and rdata←imem_rd_data on the next edge.
  - rvalid is a one-cycle pulse per grant. rdata holds its last value otherwise.

## Timing
- Reset values: FSM=LOAD, load_cnt=0, starve_cnt=0, load_err=0, core_run=0, fetch_rvalid=0, dbg_rvalid=0, fetch_rdata=0, dbg_rdata=0.
- Combinational outputs during reset: ld_ready=1; all grants and imem_wr_en follow the rules above (fetch_gnt=0 in LOAD).
- Write latency 0: the beat is in the memory after the accepting edge.
- Read latency 1 cycle, grant to rvalid.
- A fetch read of a word written on edge N is correct from cycle N+1 onward.
- core_run rises the cycle after the final beat is accepted, and falls the cycle after reload_req.
- A grant issued in the reload_req cycle still returns rvalid next cycle.
- A rst assertion mid-load returns to LOAD with load_cnt=0. Memory contents are not cleared by this block.
- Simultaneous fetch_req and dbg_req at starve_cnt<STARVE_LIMIT: fetch wins.

## Test plan
- Boot load 3 beats (0x00500093, 0x00100113, 0x002081B3; last on 3rd) → wr_addr 0,1,2; core_run=1 the cycle after; load_err=0.
- Load 16 beats, ld_last never set → 16 writes, RUN entered after beat 16, load_err=1, ld_ready=0 afterwards.
- RUN with fetch_req held, addr 2 → fetch_gnt every cycle, fetch_rvalid next cycle, fetch_rdata=0x002081B3.
- fetch_req and dbg_req held continuously, STARVE_LIMIT=4 → dbg_gnt exactly once per 5 cycles; dbg_rdata matches dbg_addr contents.
- reload_req in RUN, then 1 beat 0xDEADBEEF with last → core_run low for the load window, word 0 = 0xDEADBEEF, load_err cleared.
- rst asserted after 2 of 5 beats → ld_ready=1, next beat writes addr 0, core_run=0, rvalid outputs 0.
